bwt_bi_extension: RTL and testbench

- One-step FM-index bidirectional extension (BWA-MEM `bwt_extend`) of a bi-interval (k,l,s) by one base, forward or backward.
- Sits between the SMEM controller and the occurrence-lookup unit (OccLookup over AXI4-Lite).
- Per request: issues one dual-position Occ lookup, combines the result with the BWT accumulated counts and primary position, and returns the new bi-interval.

---
 rtl/bwt_bi_extension.sv | 240 ++++++++++++++++++++++++
 tb/tb_bwt_bi_extension.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bwt_bi_extension.sv
// ---------------------------------------------------------------------------
// bwt_bi_extension
//   One-step FM-index bidirectional extension of a bi-interval (k,l,s) by one
//   base, backward or forward. Each request issues one dual-position Occ
//   lookup, combines the returned counts with the accumulated symbol counts
//   (L2) and the BWT primary position, and returns the new bi-interval.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   a_in, dir_in              base (A,C,G,T=0..3, 4..7 = $), 0=backward 1=forward
//   k_in, l_in, s_in, start   request bi-interval and request pulse
//   k_out, l_out, s_out       result bi-interval (held until the next result)
//   finish, busy              one-cycle done pulse, request in progress
//   acc_cnt_in, pri_pos_in    L2[0..3] and primary position
//   bwt_params_valid          loads acc_cnt_in / pri_pos_in
//   occ_k, occ_ks, occ_lookup Occ query positions and one-cycle request
//   occ_val_k, occ_val_ks     Occ(A..T) at occ_k / occ_ks
//   occ_val_valid             lookup result strobe
//
// Build option
//   EXT_OUT_REG_EN : adds one output register stage; results, finish and the
//                    end of busy all move one cycle later.
// ---------------------------------------------------------------------------
module bwt_bi_extension #(
  parameter int KLS_W = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            a_in,
  input  logic                  dir_in,
  input  logic [KLS_W-1:0]      k_in,
  input  logic [KLS_W-1:0]      l_in,
  input  logic [KLS_W-1:0]      s_in,
  input  logic                  start,
  output logic [KLS_W-1:0]      k_out,
  output logic [KLS_W-1:0]      l_out,
  output logic [KLS_W-1:0]      s_out,
  output logic                  finish,
  output logic                  busy,
  input  logic [3:0][KLS_W-1:0] acc_cnt_in,
  input  logic [KLS_W-1:0]      pri_pos_in,
  input  logic                  bwt_params_valid,
  output logic [KLS_W-1:0]      occ_k,
  output logic [KLS_W-1:0]      occ_ks,
  output logic                  occ_lookup,
  input  logic [3:0][KLS_W-1:0] occ_val_k,
  input  logic [3:0][KLS_W-1:0] occ_val_ks,
  input  logic                  occ_val_valid
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CALC, S_DONE} state_t;

  localparam logic [KLS_W-1:0] ONE = KLS_W'(1);

  state_t                  r_state;
  logic [3:0][KLS_W-1:0]   r_l2, r_req_l2;
  logic [KLS_W-1:0]        r_pri, r_req_pri;
  logic                    r_loaded;
  logic                    r_dollar, r_dir;
  logic [1:0]              r_b;
  logic [KLS_W-1:0]        r_p, r_q, r_s;
  logic [3:0][KLS_W-1:0]   r_tk, r_tl;
  logic [KLS_W-1:0]        r_occ_k, r_occ_ks;
  logic                    r_occ_lookup, r_busy, r_fin;
  logic [KLS_W-1:0]        r_res_k, r_res_l, r_res_s;

  logic                    w_busy, w_accept, w_f;
  logic [KLS_W-1:0]        w_p_in, w_q_in, w_ps, w_np, w_nq, w_sum;
  logic [1:0]              w_b_in;
  logic [3:0][KLS_W-1:0]   w_cnt;

  // Operand selection for the incoming request: forward extension works on
  // the reverse-complement strand, so p/q swap and the base is complemented.
  assign w_p_in   = dir_in ? l_in : k_in;
  assign w_q_in   = dir_in ? k_in : l_in;
  assign w_b_in   = dir_in ? (2'd3 - a_in[1:0]) : a_in[1:0];
  assign w_accept = start && r_loaded && !w_busy && (r_state == S_IDLE);

  assign w_ps = r_p + r_s;

  // Extension arithmetic on the latched request, consumed in CALC.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 4; i++) begin
      w_cnt[i] = r_tl[i] - r_tk[i];
    end
    for (int j = 0; j < 4; j++) begin
      if (j > int'(r_b)) w_sum = w_sum + w_cnt[j];
    end
    // The primary position ($ row) falls inside [p, p+s-1]: it adds one to q.
    w_f  = (r_p <= r_req_pri) && ((w_ps - ONE) >= r_req_pri);
    w_np = r_req_l2[r_b] + ONE + r_tk[r_b];
    w_nq = r_q + {{(KLS_W-1){1'b0}}, w_f} + w_sum;
  end

  // BWT parameters may be reloaded at any time; a request snapshots them.
  // NOTE: the small L2 array is reset like any other register because its
  // contents are visible state (zero until first load), not bulk storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_l2     <= '0;
      r_pri    <= '0;
      r_loaded <= 1'b0;
    end else if (bwt_params_valid) begin
      r_l2     <= acc_cnt_in;
      r_pri    <= pri_pos_in;
      r_loaded <= 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_req_l2     <= '0;
      r_req_pri    <= '0;
      r_dollar     <= 1'b0;
      r_dir        <= 1'b0;
      r_b          <= '0;
      r_p          <= '0;
      r_q          <= '0;
      r_s          <= '0;
      r_tk         <= '0;
      r_tl         <= '0;
      r_occ_k      <= '0;
      r_occ_ks     <= '0;
      r_occ_lookup <= 1'b0;
      r_busy       <= 1'b0;
      r_fin        <= 1'b0;
      r_res_k      <= '0;
      r_res_l      <= '0;
      r_res_s      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_fin <= 1'b0;
          if (w_accept) begin
            r_req_l2  <= r_l2;
            r_req_pri <= r_pri;
            r_dollar  <= a_in[2];
            r_dir     <= dir_in;
            r_b       <= w_b_in;
            r_busy    <= 1'b1;
            if (a_in[2]) begin
              // $ needs no lookup: k/l are carried through unchanged and the
              // CALC slot only registers them, giving the 2-cycle latency.
              r_p     <= k_in;
              r_q     <= l_in;
              r_state <= S_CALC;
            end else begin
              r_p          <= w_p_in;
              r_q          <= w_q_in;
              r_s          <= s_in;
              r_occ_k      <= w_p_in - ONE;
              r_occ_ks     <= w_p_in + s_in - ONE;
              r_occ_lookup <= 1'b1;
              r_state      <= S_REQ;
            end
          end
        end
        S_REQ, S_WAIT: begin
          r_occ_lookup <= 1'b0;
          if (occ_val_valid) begin
            // Occ(-1) is zero by definition; the returned value is ignored.
            r_tk    <= (r_p == '0) ? '0 : occ_val_k;
            r_tl    <= (w_ps == '0) ? '0 : occ_val_ks;
            r_state <= S_CALC;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_CALC: begin
          if (r_dollar) begin
            r_res_k <= r_p;
            r_res_l <= r_q;
            r_res_s <= '0;
          end else begin
            r_res_k <= r_dir ? w_nq : w_np;
            r_res_l <= r_dir ? w_np : w_nq;
            r_res_s <= w_cnt[r_b];
          end
          r_fin   <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_fin    <= 1'b0;
          r_busy   <= 1'b0;
          r_occ_k  <= '0;
          r_occ_ks <= '0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign occ_k      = r_occ_k;
  assign occ_ks     = r_occ_ks;
  assign occ_lookup = r_occ_lookup;

`ifdef EXT_OUT_REG_EN
  logic [KLS_W-1:0] r_x_k, r_x_l, r_x_s;
  logic             r_fin_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x_k   <= '0;
      r_x_l   <= '0;
      r_x_s   <= '0;
      r_fin_d <= 1'b0;
    end else begin
      r_fin_d <= r_fin;
      if (r_fin) begin
        r_x_k <= r_res_k;
        r_x_l <= r_res_l;
        r_x_s <= r_res_s;
      end
    end
  end

  // busy also covers the extra output cycle so no start overlaps it.
  assign w_busy = r_busy | r_fin_d;
  assign k_out  = r_x_k;
  assign l_out  = r_x_l;
  assign s_out  = r_x_s;
  assign finish = r_fin_d;
`else
  assign w_busy = r_busy;
  assign k_out  = r_res_k;
  assign l_out  = r_res_l;
  assign s_out  = r_res_s;
  assign finish = r_fin;
`endif

  assign busy = w_busy;

endmodule

// File: tb/tb_bwt_bi_extension.sv
// ---------------------------------------------------------------------------
// tb_bwt_bi_extension
//   Directed self-checking bench for bwt_bi_extension. Stimulus and sampling
//   both happen 1 ns after the rising edge; Occ responses are driven by hand.
// ---------------------------------------------------------------------------
module tb_bwt_bi_extension;

  localparam int W = 40;
`ifdef EXT_OUT_REG_EN
  localparam int XLAT = 1;
`else
  localparam int XLAT = 0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [2:0]          a_in = '0;
  logic                dir_in = 1'b0;
  logic [W-1:0]        k_in = '0, l_in = '0, s_in = '0;
  logic                start = 1'b0;
  logic [W-1:0]        k_out, l_out, s_out;
  logic                finish, busy;
  logic [3:0][W-1:0]   acc_cnt_in = '0;
  logic [W-1:0]        pri_pos_in = '0;
  logic                bwt_params_valid = 1'b0;
  logic [W-1:0]        occ_k, occ_ks;
  logic                occ_lookup;
  logic [3:0][W-1:0]   occ_val_k = '0, occ_val_ks = '0;
  logic                occ_val_valid = 1'b0;

  int errors = 0;
  int checks = 0;
  int n_fin = 0;
  int n_look = 0;

  bwt_bi_extension #(.KLS_W(W)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .dir_in(dir_in),
    .k_in(k_in), .l_in(l_in), .s_in(s_in), .start(start),
    .k_out(k_out), .l_out(l_out), .s_out(s_out),
    .finish(finish), .busy(busy),
    .acc_cnt_in(acc_cnt_in), .pri_pos_in(pri_pos_in),
    .bwt_params_valid(bwt_params_valid),
    .occ_k(occ_k), .occ_ks(occ_ks), .occ_lookup(occ_lookup),
    .occ_val_k(occ_val_k), .occ_val_ks(occ_val_ks),
    .occ_val_valid(occ_val_valid)
  );

  always #5 clk = ~clk;

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (finish) n_fin++;
    if (occ_lookup) n_look++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_params(input logic [W-1:0] pri);
    acc_cnt_in       = {40'd6, 40'd4, 40'd2, 40'd0};
    pri_pos_in       = pri;
    bwt_params_valid = 1'b1;
    tick();
    bwt_params_valid = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] a, input logic d,
                          input logic [W-1:0] k, input logic [W-1:0] l,
                          input logic [W-1:0] s);
    a_in = a; dir_in = d; k_in = k; l_in = l; s_in = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic give_occ(input int wait_cyc, input logic [W-1:0] tkv,
                          input logic [W-1:0] tlv);
    repeat (wait_cyc) tick();
    occ_val_k     = {tkv, tkv, tkv, tkv};
    occ_val_ks    = {tlv, tlv, tlv, tlv};
    occ_val_valid = 1'b1;
    tick();
    occ_val_valid = 1'b0;
  endtask

  // Waits (bounded) for finish; returns the number of ticks it took.
  task automatic wait_finish(input string tag, output int cyc);
    cyc = 0;
    while (!finish && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_finish"}, 64'(finish), 64'd1);
  endtask

  int cyc;
  int f0, l0;

  initial begin
    // ---------------- reset ----------------
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_finish", 64'(finish), 64'd0);
    check("rst_k_out", 64'(k_out), 64'd0);
    check("rst_occ_k", 64'(occ_k), 64'd0);
    rst = 1'b1;
    tick();

    // ---------------- start without params ----------------
    do_start(3'd1, 1'b0, 40'd0, 40'd0, 40'd9);
    check("nop_busy", 64'(busy), 64'd0);
    repeat (4) tick();
    check("nop_lookup", 64'(n_look), 64'd0);
    check("nop_finish", 64'(n_fin), 64'd0);

    load_params(40'd4);

    // ---------------- backward, a=C ----------------
    do_start(3'd1, 1'b0, 40'd0, 40'd0, 40'd9);
    check("bw_lookup", 64'(occ_lookup), 64'd1);
    check("bw_busy", 64'(busy), 64'd1);
    check("bw_occ_k", 64'(occ_k), 64'hFF_FFFF_FFFF);
    check("bw_occ_ks", 64'(occ_ks), 64'd8);
    give_occ(0, 40'd0, 40'd2);
    check("bw_lookup_1cyc", 64'(occ_lookup), 64'd0);
    wait_finish("bw", cyc);
    check("bw_latency", 64'(cyc), 64'(1 + XLAT));
    check("bw_k_out", 64'(k_out), 64'd3);
    check("bw_l_out", 64'(l_out), 64'd5);
    check("bw_s_out", 64'(s_out), 64'd2);
    tick();
    check("bw_finish_pulse", 64'(finish), 64'd0);
    check("bw_busy_end", 64'(busy), 64'd0);
    check("bw_hold_k", 64'(k_out), 64'd3);

    // ---------------- forward, a=C (b=G) ----------------
    do_start(3'd1, 1'b1, 40'd0, 40'd0, 40'd9);
    give_occ(1, 40'd0, 40'd2);
    wait_finish("fw", cyc);
    check("fw_k_out", 64'(k_out), 64'd3);
    check("fw_l_out", 64'(l_out), 64'd5);
    check("fw_s_out", 64'(s_out), 64'd2);
    tick();

    // ---------------- force-zero tk, primary inside ----------------
    do_start(3'd0, 1'b0, 40'd0, 40'd0, 40'd9);
    give_occ(2, 40'd7, 40'd2);
    wait_finish("fz", cyc);
    check("fz_k_out", 64'(k_out), 64'd1);
    check("fz_l_out", 64'(l_out), 64'd7);
    check("fz_s_out", 64'(s_out), 64'd2);
    tick();

    // ---------------- primary outside (pri=20) ----------------
    load_params(40'd20);
    do_start(3'd0, 1'b0, 40'd0, 40'd0, 40'd9);
    give_occ(0, 40'd7, 40'd2);
    wait_finish("po", cyc);
    check("po_k_out", 64'(k_out), 64'd1);
    check("po_l_out", 64'(l_out), 64'd6);
    check("po_s_out", 64'(s_out), 64'd2);
    tick();

    // ---------------- second start during WAIT ignored ----------------
    load_params(40'd4);
    f0 = n_fin;
    l0 = n_look;
    do_start(3'd1, 1'b0, 40'd0, 40'd0, 40'd9);
    tick();
    do_start(3'd3, 1'b1, 40'd100, 40'd200, 40'd50);
    check("dbl_busy", 64'(busy), 64'd1);
    give_occ(0, 40'd0, 40'd2);
    wait_finish("dbl", cyc);
    check("dbl_k_out", 64'(k_out), 64'd3);
    check("dbl_l_out", 64'(l_out), 64'd5);
    check("dbl_s_out", 64'(s_out), 64'd2);
    repeat (6) tick();
    check("dbl_one_finish", 64'(n_fin - f0), 64'd1);
    check("dbl_one_lookup", 64'(n_look - l0), 64'd1);

    // ---------------- $ base ----------------
    l0 = n_look;
    do_start(3'd4, 1'b0, 40'd3, 40'd5, 40'd2);
    wait_finish("dl", cyc);
    check("dl_latency", 64'(cyc), 64'(1 + XLAT));
    check("dl_k_out", 64'(k_out), 64'd3);
    check("dl_l_out", 64'(l_out), 64'd5);
    check("dl_s_out", 64'(s_out), 64'd0);
    check("dl_no_lookup", 64'(n_look - l0), 64'd0);
    tick();

    // ---------------- reset during WAIT ----------------
    do_start(3'd1, 1'b0, 40'd0, 40'd0, 40'd9);
    tick();
    check("rw_in_wait", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rw_busy", 64'(busy), 64'd0);
    check("rw_k_out", 64'(k_out), 64'd0);
    check("rw_l_out", 64'(l_out), 64'd0);
    check("rw_occ_ks", 64'(occ_ks), 64'd0);
    tick();
    rst = 1'b1;
    f0 = n_fin;
    give_occ(0, 40'd0, 40'd2);
    repeat (5) tick();
    check("rw_no_finish", 64'(n_fin - f0), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
